// File: rtl/leaf_pkt_pkg.sv
// ============================================================================
// Module      : leaf_pkt_pkg
// Description : Field widths, bit positions and credit constants for the
//               leaf output packet {valid, dest_leaf, dest_port, addr, payload}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package leaf_pkt_pkg;

  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 5;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int PACKET_BITS           = 1 + NUM_LEAF_BITS + NUM_PORT_BITS
                                         + NUM_ADDR_BITS + PAYLOAD_BITS;

  localparam int VALID_BIT             = PACKET_BITS - 1;
  localparam int LEAF_LSB              = VALID_BIT - NUM_LEAF_BITS;
  localparam int PORT_LSB              = LEAF_LSB - NUM_PORT_BITS;
  localparam int ADDR_LSB              = PORT_LSB - NUM_ADDR_BITS;

  // One extra bit so a full receiver buffer (2**NUM_ADDR_BITS) is representable.
  localparam int CREDIT_BITS           = NUM_ADDR_BITS + 1;
  localparam int CREDIT_MAX            = 2 ** NUM_ADDR_BITS;
  localparam int FREESPACE_UPDATE_SIZE = 64;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; searches upward from the last granted
//               index, wrapping mod N, and produces a one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  localparam int PTR_BITS = (N > 1) ? $clog2(N) : 1;

  logic [PTR_BITS-1:0] last_q;
  logic [PTR_BITS-1:0] last_d;
  logic [PTR_BITS-1:0] w_cand;
  logic                w_found;

  always_comb begin
    gnt_o   = '0;
    last_d  = last_q;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      if (int'(last_q) + k >= N) begin
        w_cand = PTR_BITS'(int'(last_q) + k - N);
      end else begin
        w_cand = PTR_BITS'(int'(last_q) + k);
      end
      if (!w_found && req_i[w_cand]) begin
        w_found       = 1'b1;
        gnt_o[w_cand] = 1'b1;
        last_d        = w_cand;
      end
    end
    if (!advance_i) begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= PTR_BITS'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/leaf_out_arbiter.sv
// ============================================================================
// Module      : leaf_out_arbiter
// Description : Shares the leaf's single BFT output among NUM_OUT_PORTS user
//               streams using round-robin gated by destination config/credits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leaf_out_arbiter
  import leaf_pkt_pkg::*;
#(
  parameter int NUM_OUT_PORTS = 6
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dport,
  input  logic                                  cred_vld,
  input  logic [NUM_PORT_BITS-1:0]              cred_port,
  input  logic                                  resend,
  input  logic                                  pkt_rdy,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft
);

  logic [NUM_OUT_PORTS-1:0] cfg_valid_q, cfg_valid_d;
  logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_d   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_q  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_d  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_d   [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
  logic [PACKET_BITS-1:0]   dout_q, dout_d;

  logic [NUM_OUT_PORTS-1:0] w_eligible;
  logic [NUM_OUT_PORTS-1:0] w_req;
  logic [NUM_OUT_PORTS-1:0] w_gnt;
  logic                     w_slot_free;
  logic                     w_issue_en;
  logic [NUM_LEAF_BITS-1:0] w_sel_leaf;
  logic [NUM_PORT_BITS-1:0] w_sel_dport;
  logic [NUM_ADDR_BITS-1:0] w_sel_addr;
  logic [PAYLOAD_BITS-1:0]  w_sel_data;
  logic [CREDIT_BITS:0]     w_credit_sum;

  assign w_slot_free = ~dout_q[VALID_BIT] | pkt_rdy;
  assign w_issue_en  = w_slot_free & ~resend;
  assign w_req       = w_eligible & {NUM_OUT_PORTS{w_issue_en}};

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_eligible[i] = vld_user2interface[i] & cfg_valid_q[i] & (credit_q[i] != '0);
    end
  end

  rr_arbiter #(
    .N (NUM_OUT_PORTS)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (w_req),
    .advance_i (w_issue_en),
    .gnt_o     (w_gnt)
  );

  assign ack_interface2user = w_gnt;

  // Grant is one-hot, so OR-ing the gated fields is a plain mux.
  always_comb begin
    w_sel_leaf  = '0;
    w_sel_dport = '0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (w_gnt[i]) begin
        w_sel_leaf  = w_sel_leaf  | leaf_q[i];
        w_sel_dport = w_sel_dport | dport_q[i];
        w_sel_addr  = w_sel_addr  | addr_q[i];
        w_sel_data  = w_sel_data  | din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (!resend) begin
      if (|w_gnt) begin
        dout_d[VALID_BIT]                   = 1'b1;
        dout_d[LEAF_LSB +: NUM_LEAF_BITS]   = w_sel_leaf;
        dout_d[PORT_LSB +: NUM_PORT_BITS]   = w_sel_dport;
        dout_d[ADDR_LSB +: NUM_ADDR_BITS]   = w_sel_addr;
        dout_d[0 +: PAYLOAD_BITS]           = w_sel_data;
      end else if (w_slot_free) begin
        dout_d[VALID_BIT] = 1'b0;
      end
    end
  end

  // A config write overrides the grant/credit update of the same cycle.
  always_comb begin
    cfg_valid_d  = cfg_valid_q;
    w_credit_sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      leaf_d[i]    = leaf_q[i];
      dport_d[i]   = dport_q[i];
      addr_d[i]    = addr_q[i] + NUM_ADDR_BITS'(w_gnt[i]);
      w_credit_sum = {1'b0, credit_q[i]}
                   + ((cred_vld && cred_port == NUM_PORT_BITS'(i))
                      ? (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE) : '0)
                   - (CREDIT_BITS+1)'(w_gnt[i]);
      if (w_credit_sum > (CREDIT_BITS+1)'(CREDIT_MAX)) begin
        credit_d[i] = CREDIT_BITS'(CREDIT_MAX);
      end else begin
        credit_d[i] = w_credit_sum[CREDIT_BITS-1:0];
      end
      if (cfg_we && cfg_port == NUM_PORT_BITS'(i)) begin
        cfg_valid_d[i] = 1'b1;
        leaf_d[i]      = cfg_leaf;
        dport_d[i]     = cfg_dport;
        addr_d[i]      = '0;
        credit_d[i]    = CREDIT_BITS'(CREDIT_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_valid_q <= '0;
      dout_q      <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
        addr_q[i]   <= '0;
        credit_q[i] <= CREDIT_BITS'(CREDIT_MAX);
      end
    end else begin
      cfg_valid_q <= cfg_valid_d;
      dout_q      <= dout_d;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= leaf_d[i];
        dport_q[i]  <= dport_d[i];
        addr_q[i]   <= addr_d[i];
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign dout_leaf_interface2bft = dout_q;

endmodule

`default_nettype wire
